imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the pipeline's instruction memory: it writes the words the fetch stage later reads. It receives a framed byte stream on a valid/ready interface, assembles little-endian 32-bit words, and issues one write per word to the instruction memory's write port. It holds the CPU in reset while a load is in progress and reports completion or a checksum failure.

## Interface

- `SYNC_BYTE`, default `8'hA5`: frame start marker.
- `ADDR_BASE`, default `32'h0000_0000`: byte address of the first written word; must be word aligned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: one-cycle write strobe to instruction memory.
- `mem_addr` out 32: byte address of the write, word aligned.
- `mem_wdata` out 32: word to write.
- `cpu_hold` out 1: holds the core in reset while a load is in progress.
- `load_done` out 1: one-cycle pulse when a frame completes with a good checksum.
- `load_err` out 1: sticky checksum-failure flag.

## Operation

- Frame format: `SYNC_BYTE`, then count byte N, then 4·N data bytes, then checksum byte.
  - N = 0 means 256 words, which is the full 1 KB memory.
  - Data bytes are little-endian per word: byte 0 goes to [7:0] and byte 3 to [31:24].
  - The checksum is the XOR of all 4·N data bytes.
- A byte is accepted on a rising edge with `in_valid && in_ready`.
- States and transitions:
  - SYNC: a byte equal to `SYNC_BYTE` → COUNT. Sets `cpu_hold`, clears `load_err`, word index = 0, checksum accumulator = 0, byte lane = 0. Any other byte is accepted and discarded.
  - COUNT: the accepted byte is latched as N (0 is treated as 256) → DATA.
  - DATA: each accepted byte goes into the current lane and is XORed into the accumulator; the lane increments. When lane 3 is accepted → WRITE.
  - WRITE: one cycle; no byte is accepted.
    - Drives `mem_we=1`, `mem_addr = ADDR_BASE + 4·index`, `mem_wdata` = the assembled word.
    - Then index increments and lane resets.
    - Next state: DATA if index+1 < N, else CSUM.
  - CSUM: accepted byte equal to the accumulator → DONE. A mismatch → SYNC with `load_err=1` and `cpu_hold=0`.
  - DONE: one cycle. `load_done=1`, `cpu_hold` clears at the end of this cycle, no byte is accepted → SYNC.
- `in_ready` = 1 in SYNC, COUNT, DATA and CSUM; 0 in WRITE and DONE. It is a combinational decode of state.
- `mem_addr` and `mem_wdata` hold their last value outside WRITE. They are registered, so they are stable during the whole WRITE cycle.
- Word index is 9 bits. `mem_addr` never exceeds `ADDR_BASE + 1020`; there is no wrap-around.
- Back-to-back frames are allowed: a new `SYNC_BYTE` is accepted on the cycle after DONE.

## Timing

- Reset values (applied immediately, asynchronously):
  - state = SYNC
  - `in_ready=1`, `mem_we=0`, `mem_addr=ADDR_BASE`, `mem_wdata=0`
  - `cpu_hold=0`, `load_done=0`, `load_err=0`
- Write latency: `mem_we` is high exactly in the cycle following the edge that accepted the word's 4th byte.
- Minimum cycles per frame with `in_valid` held high: 2 + 5·N + 1 + 1, covering SYNC and COUNT, DATA plus WRITE per word, CSUM, and DONE.
- Gaps in `in_valid` stall the FSM in place; partial-word state is retained.
- Reset mid-frame aborts the frame and drops `cpu_hold` immediately. Words already written stay in memory; no write is issued for a partial word.
- `load_err` stays set until the next accepted `SYNC_BYTE` or reset. `load_done` and `load_err` are never high together.

## Test plan

- **Single word:** stream A5, 01, 93, 00, 00, 01, 92. Expect:
  - one `mem_we` pulse with addr 0x0 and data 0x01000093;
  - `load_done` pulse, `cpu_hold` high from after A5 through DONE, `load_err=0`.
- **Full memory:** A5, 00, then 1024 bytes encoding word i = i, then the correct checksum. Expect:
  - 256 writes at addresses 0x000 through 0x3FC with data equal to the index;
  - no write beyond 0x3FC, then `load_done`.
- **Bad checksum:** as in the single-word case but with checksum 0x00. Expect:
  - the word is still written;
  - `load_err=1` and `cpu_hold=0` after CSUM, no `load_done`;
  - the next A5 clears `load_err`.
- **Garbage before sync:** 3C, FF, then the single-word frame. Expect:
  - 3C and FF accepted (`in_ready=1`) with no effect;
  - a result identical to the single-word case.
- **Backpressure and gaps:** two-word frame with `in_valid` toggling randomly. Expect:
  - `in_ready=0` exactly in the WRITE and DONE cycles;
  - words written correctly at 0x0 and 0x4.
- **Reset mid-load:** assert `rst` after 2 bytes of word 1 of a two-word frame. Expect:
  - all outputs at reset values immediately, including `cpu_hold=0`;
  - only word 0 written;
  - a fresh frame afterwards loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Program loader for the instruction memory. It takes a framed byte stream:
//    SYNC_BYTE, N, 4*N data bytes (little-endian words), XOR checksum byte.
// Each assembled word is written once to the memory write port. The CPU is
// held in reset while a frame is in progress. A good checksum produces a
// one-cycle load_done pulse; a bad one sets the sticky load_err flag.
//
// Parameters
//    SYNC_BYTE  frame start marker
//    ADDR_BASE  byte address of the first written word (word aligned)
//
// Ports
//    clk        clock, rising edge
//    rst        asynchronous active-high reset
//    in_data    stream byte
//    in_valid   in_data valid
//    in_ready   loader accepts a byte this cycle (decoded from state)
//    mem_we     one-cycle write strobe to instruction memory
//    mem_addr   word-aligned byte address of the write (registered)
//    mem_wdata  word to write (registered)
//    cpu_hold   holds the core in reset during a load
//    load_done  one-cycle pulse on a frame with good checksum
//    load_err   sticky checksum-failure flag
// ----------------------------------------------------------------------------
module imem_loader #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_COUNT,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_DONE
   } state_t;

   state_t      state_reg;
   logic [8:0]  count_reg;     // words in frame, 1..256
   logic [8:0]  index_reg;     // current word index
   logic [1:0]  lane_reg;      // byte lane within current word
   logic [7:0]  csum_reg;      // running XOR of data bytes
   logic [23:0] partial_reg;   // lanes 0..2 of the word being assembled

   logic        accept;
   logic [8:0]  index_next;

   // WRITE and DONE are the only cycles in which no byte is taken.
   assign in_ready   = (state_reg != ST_WRITE) && (state_reg != ST_DONE);
   assign accept     = in_valid && in_ready;
   assign index_next = index_reg + 9'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_SYNC;
         count_reg   <= 9'd0;
         index_reg   <= 9'd0;
         lane_reg    <= 2'd0;
         csum_reg    <= 8'd0;
         partial_reg <= 24'd0;
         mem_we      <= 1'b0;
         mem_addr    <= ADDR_BASE;
         mem_wdata   <= 32'd0;
         cpu_hold    <= 1'b0;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         // Strobes default low; they are raised for exactly one cycle.
         mem_we    <= 1'b0;
         load_done <= 1'b0;

         case (state_reg)
            ST_SYNC: begin
               // Non-sync bytes are consumed and dropped.
               if (accept && (in_data == SYNC_BYTE)) begin
                  state_reg <= ST_COUNT;
                  cpu_hold  <= 1'b1;
                  load_err  <= 1'b0;
                  index_reg <= 9'd0;
                  csum_reg  <= 8'd0;
                  lane_reg  <= 2'd0;
               end
            end

            ST_COUNT: begin
               if (accept) begin
                  // A count of 0 encodes a full 256-word image.
                  count_reg <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                  state_reg <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (accept) begin
                  csum_reg <= csum_reg ^ in_data;
                  lane_reg <= lane_reg + 2'd1;
                  case (lane_reg)
                     2'd0: partial_reg[7:0]   <= in_data;
                     2'd1: partial_reg[15:8]  <= in_data;
                     2'd2: partial_reg[23:16] <= in_data;
                     default: begin
                        // Last lane: word complete, present it registered so
                        // address/data are stable for the whole WRITE cycle.
                        mem_we    <= 1'b1;
                        mem_wdata <= {in_data, partial_reg};
                        mem_addr  <= ADDR_BASE + {21'd0, index_reg, 2'b00};
                        state_reg <= ST_WRITE;
                     end
                  endcase
               end
            end

            ST_WRITE: begin
               index_reg <= index_next;
               lane_reg  <= 2'd0;
               state_reg <= (index_next < count_reg) ? ST_DATA : ST_CSUM;
            end

            ST_CSUM: begin
               if (accept) begin
                  if (in_data == csum_reg) begin
                     load_done <= 1'b1;
                     state_reg <= ST_DONE;
                  end else begin
                     load_err  <= 1'b1;
                     cpu_hold  <= 1'b0;
                     state_reg <= ST_SYNC;
                  end
               end
            end

            ST_DONE: begin
               // Hold is released at the end of the done cycle.
               cpu_hold  <= 1'b0;
               state_reg <= ST_SYNC;
            end

            default: state_reg <= ST_SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//
// Drives framed byte streams into imem_loader and checks every write strobe,
// completion pulse and error flag against a frame-level model: the expected
// writes are simply ADDR_BASE + 4*i / word[i] for each word of a frame, and
// the expected outcome is whether the supplied checksum equals the XOR of all
// data bytes.
// ----------------------------------------------------------------------------
module tb_imem_loader;

   localparam logic [7:0]  SYNC = 8'hA5;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;

   always #5 clk = ~clk;

   imem_loader #(
      .SYNC_BYTE (SYNC),
      .ADDR_BASE (BASE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   int          tests = 0;
   int          fails = 0;
   wr_t         wq[$];          // expected writes, in order
   bit          rq[$];          // expected outcomes: 1 = done, 0 = error
   logic [31:0] fw[$];          // words of the frame being built
   int          cyc = 0;
   int          done_cyc = 0;
   int          present_cyc = 0;
   logic [31:0] last_addr = BASE;
   logic [31:0] last_data = 32'd0;
   logic        prev_err = 1'b0;
   wr_t         cw;
   bit          outcome;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Per-cycle compare against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         last_addr = BASE;
         last_data = 32'd0;
         prev_err  = 1'b0;
      end else begin
         chk("in_ready_vs_write_done", {31'd0, in_ready}, {31'd0, !(mem_we || load_done)});
         chk("done_err_exclusive", {31'd0, load_done && load_err}, 32'd0);
         if (mem_we) begin
            chk("hold_during_write", {31'd0, cpu_hold}, 32'd1);
            tests++;
            if (wq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr, mem_wdata);
            end else begin
               cw = wq.pop_front();
               if (mem_addr !== cw.a || mem_wdata !== cw.d) begin
                  fails++;
                  $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                           mem_addr, mem_wdata, cw.a, cw.d);
               end
            end
            last_addr = mem_addr;
            last_data = mem_wdata;
         end else begin
            chk("addr_hold", mem_addr, last_addr);
            chk("wdata_hold", mem_wdata, last_data);
         end
         if (load_done) begin
            done_cyc = cyc;
            tests++;
            if (rq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done: load_done 1, no outcome expected");
            end else begin
               outcome = rq.pop_front();
               if (outcome != 1'b1) begin
                  fails++;
                  $display("FAIL outcome: got load_done, expected load_err");
               end
            end
         end
         if (load_err && !prev_err) begin
            chk("hold_off_on_err", {31'd0, cpu_hold}, 32'd0);
            tests++;
            if (rq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_err: load_err 1, no outcome expected");
            end else begin
               outcome = rq.pop_front();
               if (outcome != 1'b0) begin
                  fails++;
                  $display("FAIL outcome: got load_err, expected load_done");
               end
            end
         end
         prev_err = load_err;
      end
   end

   // Present one byte (after an optional random idle gap) and wait, bounded,
   // until it is accepted. Returns on the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int gap;
      bit ok;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_data     = b;
      in_valid    = 1'b1;
      present_cyc = cyc;
      ok          = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (in_ready) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL accept_timeout: byte %h, in_ready %b, expected 1", b, in_ready);
         in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Send the frame held in fw. flip == 0 sends the correct checksum,
   // otherwise the checksum is XORed with flip.
   task automatic send_frame(input logic [7:0] flip, input int maxgap);
      logic [7:0] cs;
      int n;
      int start;
      logic [8:0] nn;
      n  = fw.size();
      nn = 9'(n);
      cs = 8'd0;
      for (int i = 0; i < n; i++) begin
         cs ^= fw[i][7:0] ^ fw[i][15:8] ^ fw[i][23:16] ^ fw[i][31:24];
         wq.push_back('{BASE + 32'(4 * i), fw[i]});
      end
      cs ^= flip;
      rq.push_back(flip == 8'd0);

      send_byte(SYNC, maxgap);
      start = present_cyc;
      chk("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
      chk("err_clear_on_sync", {31'd0, load_err}, 32'd0);
      send_byte(nn[7:0], maxgap);
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 4; k++)
            send_byte(fw[i][8*k +: 8], maxgap);
      send_byte(cs, maxgap);
      if (flip != 8'd0) begin
         chk("err_after_bad_csum", {31'd0, load_err}, 32'd1);
         chk("hold_off_after_bad_csum", {31'd0, cpu_hold}, 32'd0);
         chk("no_done_on_bad_csum", {31'd0, load_done}, 32'd0);
      end else begin
         chk("done_after_csum", {31'd0, load_done}, 32'd1);
         chk("hold_in_done", {31'd0, cpu_hold}, 32'd1);
      end
      idle(2);
      chk("hold_released", {31'd0, cpu_hold}, 32'd0);
      chk("outcome_reported", rq.size(), 32'd0);
      chk("writes_drained", wq.size(), 32'd0);
      if (maxgap == 0 && flip == 8'd0)
         chk("frame_cycles", 32'(done_cyc - start), 32'(5 * n + 3));
   endtask

   // The single-word frame as literal bytes, with literal expectations.
   task automatic send_literal();
      logic [7:0] lit [7];
      int start;
      lit = '{8'hA5, 8'h01, 8'h93, 8'h00, 8'h00, 8'h01, 8'h92};
      wq.push_back('{32'h0000_0000, 32'h0100_0093});
      rq.push_back(1'b1);
      start = 0;
      for (int i = 0; i < 7; i++) begin
         send_byte(lit[i], 0);
         if (i == 0) start = present_cyc;
      end
      chk("lit_done", {31'd0, load_done}, 32'd1);
      chk("lit_err", {31'd0, load_err}, 32'd0);
      idle(2);
      chk("lit_addr", last_addr, 32'h0000_0000);
      chk("lit_wdata", last_data, 32'h0100_0093);
      chk("lit_outcome", rq.size(), 32'd0);
      chk("lit_cycles", 32'(done_cyc - start), 32'd8);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, BASE);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
      chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
      chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
   endtask

   initial begin
      logic [7:0] g;
      logic [31:0] w0;
      logic [31:0] w1;
      int nw;

      // Reset applied asynchronously, before any clock edge.
      #1 rst = 1'b1;
      #2 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      // Single word, literal bytes.
      send_literal();

      // Garbage before sync, then the same frame.
      send_byte(8'h3C, 0);
      chk("garbage_no_hold", {31'd0, cpu_hold}, 32'd0);
      send_byte(8'hFF, 0);
      idle(1);
      send_literal();

      // Bad checksum (0x00), then a good frame clears the error on sync.
      fw = {32'h0100_0093};
      send_frame(8'h92, 0);
      chk("err_sticky", {31'd0, load_err}, 32'd1);
      fw = {32'h0100_0093};
      send_frame(8'h00, 0);

      // Two words with random gaps in in_valid.
      fw = {$urandom(), $urandom()};
      send_frame(8'h00, 3);

      // Full memory: 256 words, word i = i.
      fw = {};
      for (int i = 0; i < 256; i++) fw.push_back(32'(i));
      send_frame(8'h00, 0);
      chk("full_last_addr", last_addr, BASE + 32'h3FC);
      chk("full_last_data", last_data, 32'd255);

      // Reset after two bytes of word 1 of a two-word frame.
      w0 = $urandom();
      w1 = $urandom();
      wq.push_back('{BASE, w0});
      send_byte(SYNC, 0);
      send_byte(8'h02, 0);
      for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
      send_byte(w1[7:0], 0);
      send_byte(w1[15:8], 0);
      #2 rst = 1'b1;
      in_valid = 1'b0;
      #1 check_reset_outputs("midreset");
      chk("midreset_writes", wq.size(), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      fw = {$urandom(), $urandom()};
      send_frame(8'h00, 0);

      // Randomised frames: random length, gaps, garbage and checksum faults.
      for (int f = 0; f < 16; f++) begin
         if ($urandom_range(1, 0) == 1) begin
            g = 8'($urandom());
            if (g == SYNC) g = 8'h00;
            send_byte(g, 2);
         end
         nw = int'($urandom_range(6, 1));
         fw = {};
         for (int i = 0; i < nw; i++) fw.push_back($urandom());
         if ($urandom_range(3, 0) == 0)
            send_frame(8'($urandom_range(255, 1)), int'($urandom_range(3, 0)));
         else
            send_frame(8'h00, int'($urandom_range(3, 0)));
      end

      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
